// File: rtl/dualwatch_pkg.sv
// Shared constants for the dual-watch time reporter: time-bus field layout,
// ASCII codes, frame lengths and the reporter FSM state encoding.
package dualwatch_pkg;

  localparam int HOUR_MSB = 23;
  localparam int HOUR_LSB = 19;
  localparam int MIN_MSB  = 18;
  localparam int MIN_LSB  = 13;
  localparam int SEC_MSB  = 12;
  localparam int SEC_LSB  = 7;
  localparam int MSEC_MSB = 6;
  localparam int MSEC_LSB = 0;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int FRAME_LEN_PREFIX   = 15;
  localparam int FRAME_LEN_NOPREFIX = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SEND = 2'd2
  } state_t;

endpackage

// File: rtl/dualwatch_time_reporter_if.sv
// Byte stream handshake from the time reporter into the UART TX FIFO.
interface dualwatch_time_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dualwatch_bin2ascii2.sv
// Combinational 7-bit binary to two ASCII decimal digits, saturating at "99".
module dualwatch_bin2ascii2
  import dualwatch_pkg::*;
(
  input  logic [6:0] v,
  output logic [7:0] tens_char,
  output logic [7:0] ones_char
);

  logic [6:0] sat;
  logic [6:0] tens;
  logic [6:0] ones;

  assign sat       = (v > 7'd99) ? 7'd99 : v;
  assign tens      = sat / 7'd10;
  assign ones      = sat - (tens * 7'd10);
  assign tens_char = ASCII_ZERO + {1'b0, tens};
  assign ones_char = ASCII_ZERO + {1'b0, ones};

endmodule

// File: rtl/dualwatch_time_reporter.sv
// Renders a frozen snapshot of watch/stopwatch time as an ASCII frame, one byte
// per handshake. DUALWATCH_REPORT_PREFIX_EN adds the "W "/"S " prefix.
//
// state   | meaning
// ST_IDLE | waiting for req; snapshot taken on req
// ST_CONV | snapshot fields converted to ASCII digits
// ST_SEND | frame bytes presented on tx until the last handshake
module dualwatch_time_reporter
  import dualwatch_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = 8'h3A,
  parameter logic [7:0] DEC_CHAR = 8'h2E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        src_sel,
  input  logic [23:0] wtch_time,
  input  logic [23:0] stpw_time,
  dualwatch_time_reporter_if.master tx,
  output logic        busy,
  output logic        done
);

`ifdef DUALWATCH_REPORT_PREFIX_EN
  localparam int         FRAME_LEN = FRAME_LEN_PREFIX;
  localparam logic [3:0] POS_BASE  = 4'd0;
`else
  // Without the prefix, byte 0 maps onto frame position 2 (H1)
  localparam int         FRAME_LEN = FRAME_LEN_NOPREFIX;
  localparam logic [3:0] POS_BASE  = 4'd2;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_t      state;
  logic [23:0] snap_time;
  logic        snap_src;
  logic [63:0] digits_q;
  logic [63:0] digits_c;
  logic [3:0]  idx;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;

  dualwatch_bin2ascii2 u_hour (
    .v({2'b00, snap_time[HOUR_MSB:HOUR_LSB]}),
    .tens_char(digits_c[63:56]), .ones_char(digits_c[55:48]));
  dualwatch_bin2ascii2 u_min (
    .v({1'b0, snap_time[MIN_MSB:MIN_LSB]}),
    .tens_char(digits_c[47:40]), .ones_char(digits_c[39:32]));
  dualwatch_bin2ascii2 u_sec (
    .v({1'b0, snap_time[SEC_MSB:SEC_LSB]}),
    .tens_char(digits_c[31:24]), .ones_char(digits_c[23:16]));
  dualwatch_bin2ascii2 u_msec (
    .v(snap_time[MSEC_MSB:MSEC_LSB]),
    .tens_char(digits_c[15:8]), .ones_char(digits_c[7:0]));

  // Frame position -> byte; positions 0/1 are the optional prefix
  function automatic logic [7:0] frame_byte(input logic [3:0] pos, input logic src,
                                            input logic [63:0] dg);
    logic [7:0] b;
    case (pos)
      4'd0:    b = src ? ASCII_S : ASCII_W;
      4'd1:    b = ASCII_SPACE;
      4'd2:    b = dg[63:56];
      4'd3:    b = dg[55:48];
      4'd4:    b = SEP_CHAR;
      4'd5:    b = dg[47:40];
      4'd6:    b = dg[39:32];
      4'd7:    b = SEP_CHAR;
      4'd8:    b = dg[31:24];
      4'd9:    b = dg[23:16];
      4'd10:   b = DEC_CHAR;
      4'd11:   b = dg[15:8];
      4'd12:   b = dg[7:0];
      4'd13:   b = ASCII_CR;
      4'd14:   b = ASCII_LF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      snap_time  <= 24'h0;
      snap_src   <= 1'b0;
      digits_q   <= 64'h0;
      idx        <= 4'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            snap_time <= src_sel ? stpw_time : wtch_time;
            snap_src  <= src_sel;
            busy      <= 1'b1;
            state     <= ST_CONV;
          end
        end
        ST_CONV: begin
          digits_q   <= digits_c;
          idx        <= 4'd0;
          tx_data_q  <= frame_byte(POS_BASE, snap_src, digits_c);
          tx_valid_q <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_valid_q && tx.tx_ready) begin
            if (idx == LAST_IDX) begin
              idx        <= 4'd0;
              tx_data_q  <= 8'h00;
              tx_valid_q <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              idx       <= idx + 4'd1;
              tx_data_q <= frame_byte(POS_BASE + idx + 4'd1, snap_src, digits_q);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_dualwatch_time_reporter.sv
// Directed bench for dualwatch_time_reporter; expected frames are hand-written
// strings, with the prefix included only when DUALWATCH_REPORT_PREFIX_EN is set.
module tb_dualwatch_time_reporter;

  logic        clk;
  logic        rst;
  logic        req;
  logic        src_sel;
  logic [23:0] wtch_time;
  logic [23:0] stpw_time;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

`ifdef DUALWATCH_REPORT_PREFIX_EN
  string pfx_w = "W ";
  string pfx_s = "S ";
`else
  string pfx_w = "";
  string pfx_s = "";
`endif

  dualwatch_time_reporter_if tx_if ();

  dualwatch_time_reporter dut (
    .clk(clk), .rst(rst), .req(req), .src_sel(src_sel),
    .wtch_time(wtch_time), .stpw_time(stpw_time),
    .tx(tx_if), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pack(input int h, input int m, input int s, input int c);
    logic [4:0] hh = 5'(h);
    logic [5:0] mm = 6'(m);
    logic [5:0] ss = 6'(s);
    logic [6:0] cc = 7'(c);
    return {hh, mm, ss, cc};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse req and check the CONV cycle; returns at the negedge where byte 0 is due
  task automatic launch();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("start_busy", {7'b0, busy}, 8'h01);
    chk("start_valid", {7'b0, tx_if.tx_valid}, 8'h00);
    @(negedge clk);
  endtask

  task automatic send_frame(input string txt, input int stall_at, input int stall_n,
                            input int req_at, input logic req_in_done);
    int n;
    logic [7:0] eb;
    n = txt.len() + 2;
    for (int i = 0; i < n; i++) begin
      if (i < txt.len()) eb = txt[i];
      else if (i == txt.len()) eb = 8'h0D;
      else eb = 8'h0A;
      if (i == stall_at) begin
        tx_if.tx_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          chk("stall_valid", {7'b0, tx_if.tx_valid}, 8'h01);
          chk("stall_data", tx_if.tx_data, eb);
          @(negedge clk);
        end
        tx_if.tx_ready = 1'b1;
      end
      chk("byte_valid", {7'b0, tx_if.tx_valid}, 8'h01);
      chk($sformatf("byte%0d", i), tx_if.tx_data, eb);
      chk("byte_done", {7'b0, done}, 8'h00);
      if (i == req_at) req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    chk("end_valid", {7'b0, tx_if.tx_valid}, 8'h00);
    chk("end_busy", {7'b0, busy}, 8'h00);
    chk("end_done", {7'b0, done}, 8'h01);
    req = req_in_done;
    @(negedge clk);
    req = 1'b0;
    chk("done_once", {7'b0, done}, 8'h00);
    chk("post_busy", {7'b0, busy}, {7'b0, req_in_done});
    chk("post_valid", {7'b0, tx_if.tx_valid}, 8'h00);
  endtask

  initial begin
    rst = 1'b0;
    req = 1'b0;
    src_sel = 1'b0;
    wtch_time = 24'h0;
    stpw_time = 24'h0;
    tx_if.tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {7'b0, tx_if.tx_valid}, 8'h00);
    chk("rst_data", tx_if.tx_data, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_done", {7'b0, done}, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // Basic watch frame, ready held high
    wtch_time = pack(13, 5, 42, 7);
    src_sel = 1'b0;
    launch();
    send_frame({pfx_w, "13:05:42.07"}, -1, 0, -1, 1'b0);

    // Backpressure on byte 3
    launch();
    send_frame({pfx_w, "13:05:42.07"}, 3, 5, -1, 1'b0);

    // Stopwatch with saturated centiseconds; inputs change after capture
    src_sel = 1'b1;
    stpw_time = pack(0, 0, 59, 127);
    launch();
    stpw_time = pack(1, 2, 3, 4);
    src_sel = 1'b0;
    send_frame({pfx_s, "00:00:59.99"}, -1, 0, -1, 1'b0);

    // req while busy is dropped
    wtch_time = pack(10, 20, 30, 40);
    launch();
    send_frame({pfx_w, "10:20:30.40"}, -1, 0, 5, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("no_requeue_valid", {7'b0, tx_if.tx_valid}, 8'h00);
      chk("no_requeue_busy", {7'b0, busy}, 8'h00);
    end

    // req in the done cycle starts the next frame immediately
    launch();
    send_frame({pfx_w, "10:20:30.40"}, -1, 0, -1, 1'b1);
    @(negedge clk);
    send_frame({pfx_w, "10:20:30.40"}, -1, 0, -1, 1'b0);

    // Reset mid-frame at byte 7
    wtch_time = pack(8, 9, 10, 11);
    launch();
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk("pre_rst_valid", {7'b0, tx_if.tx_valid}, 8'h01);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_valid", {7'b0, tx_if.tx_valid}, 8'h00);
    chk("abort_busy", {7'b0, busy}, 8'h00);
    chk("abort_done", {7'b0, done}, 8'h00);
    chk("abort_data", tx_if.tx_data, 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("quiet_valid", {7'b0, tx_if.tx_valid}, 8'h00);
      chk("quiet_done", {7'b0, done}, 8'h00);
    end
    launch();
    send_frame({pfx_w, "08:09:10.11"}, -1, 0, -1, 1'b0);

    // Boundary values: 23:59, out-of-range hour rendered as-is
    wtch_time = pack(23, 59, 0, 0);
    launch();
    send_frame({pfx_w, "23:59:00.00"}, -1, 0, -1, 1'b0);
    src_sel = 1'b1;
    stpw_time = pack(31, 7, 8, 100);
    launch();
    send_frame({pfx_s, "31:07:08.99"}, -1, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
